// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding and key constants for the keypad emulator.
package keypad_pkg;
    typedef enum logic [2:0] {S_IDLE, S_BOUNCE_IN, S_HOLD, S_BOUNCE_OUT, S_GAP} state_t;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam int NUM_COLS = 3;
    localparam int NUM_ROWS = 4;
endpackage

// File: rtl/keypad_key_map.sv
// keypad_key_map: key code to (column, row) of the 3x4 keypad; code_ok flags codes 0-11.
module keypad_key_map
    import keypad_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [1:0] o_col,
    output logic [1:0] o_row,
    output logic       o_code_ok
);
    always_comb begin
        o_col = 2'd0;
        o_row = 2'd0;
        o_code_ok = 1'b1;
        case (i_code)
            4'd1:     begin o_col = 2'd0; o_row = 2'd0; end
            4'd2:     begin o_col = 2'd1; o_row = 2'd0; end
            4'd3:     begin o_col = 2'd2; o_row = 2'd0; end
            4'd4:     begin o_col = 2'd0; o_row = 2'd1; end
            4'd5:     begin o_col = 2'd1; o_row = 2'd1; end
            4'd6:     begin o_col = 2'd2; o_row = 2'd1; end
            4'd7:     begin o_col = 2'd0; o_row = 2'd2; end
            4'd8:     begin o_col = 2'd1; o_row = 2'd2; end
            4'd9:     begin o_col = 2'd2; o_row = 2'd2; end
            KEY_STAR: begin o_col = 2'd0; o_row = 2'd3; end
            4'd0:     begin o_col = 2'd1; o_row = 2'd3; end
            KEY_HASH: begin o_col = 2'd2; o_row = 2'd3; end
            default:  o_code_ok = 1'b0;
        endcase
    end
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: presses one commanded key with bounce, hold and release gap,
// answering the scanner's column select with the key's row line combinationally.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 64,
    parameter int GAP_CYCLES    = 32,
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          key_code,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [NUM_COLS-1:0] column_sel,
    output logic [NUM_ROWS-1:0] scan_data,
    output logic                busy,
    output logic                done,
    output logic                err
);
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_col, r_row, w_col, w_row;
    logic             w_ok, w_accept, w_press, r_done, r_err;

    keypad_key_map u_map (.i_code(key_code), .o_col(w_col), .o_row(w_row), .o_code_ok(w_ok));

    assign w_accept = key_valid && key_ready;

    // Only the decoded position is kept; later key_code changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_col   <= 2'd0;
            r_row   <= 2'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
            r_done  <= r_state == S_GAP && w_next == S_IDLE;
            r_err   <= w_accept && !w_ok;
            if (w_accept) begin
                r_col <= w_col;
                r_row <= w_row;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (w_accept) w_next = w_ok ? S_BOUNCE_IN : S_GAP;
            S_BOUNCE_IN:  if (r_cnt == CNT_W'(BOUNCE_CYCLES - 1)) w_next = S_HOLD;
            S_HOLD:       if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) w_next = S_BOUNCE_OUT;
            S_BOUNCE_OUT: if (r_cnt == CNT_W'(BOUNCE_CYCLES - 1)) w_next = S_GAP;
            S_GAP:        if (r_cnt == CNT_W'(GAP_CYCLES - 1)) w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    // Bounce phases chatter on counter parity, starting pressed.
    always_comb begin
        w_press   = (r_state == S_HOLD) ||
                    ((r_state == S_BOUNCE_IN || r_state == S_BOUNCE_OUT) && !r_cnt[0]);
        key_ready = r_state == S_IDLE;
        busy      = !key_ready;
        done      = r_done;
        err       = r_err;
        scan_data = (w_press && |(column_sel & (NUM_COLS'(1) << r_col))) ?
                    NUM_ROWS'(1) << r_row : '0;
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: random commands, column selects and resets checked against
// a timeline model of each key press.
module tb_keypad_emulator;
    localparam int B = 2, H = 4, G = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic [2:0] column_sel;
    logic [3:0] scan_data;
    logic       busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    bit m_active, m_ok, m_done, m_err;
    int m_k, m_len, m_col, m_row;

    keypad_emulator #(.BOUNCE_CYCLES(B), .HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
        .key_ready(key_ready), .column_sel(column_sel), .scan_data(scan_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit pressed(input int k);
        if (k < B) return k % 2 == 0;
        if (k < B + H) return 1'b1;
        if (k < 2 * B + H) return (k - B - H) % 2 == 0;
        return 1'b0;
    endfunction

    // Model advances one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit ready;
        ready = !m_active;
        m_done = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_k = 0;
        end else if (ready && key_valid) begin
            m_active = 1'b1;
            m_k = 0;
            m_ok = key_code <= 4'd11;
            m_err = !m_ok;
            m_len = m_ok ? 2 * B + H + G : G;
            if (key_code == 4'd0) begin m_col = 1; m_row = 3; end
            else if (key_code == 4'd10) begin m_col = 0; m_row = 3; end
            else if (key_code == 4'd11) begin m_col = 2; m_row = 3; end
            else begin m_col = (int'(key_code) - 1) % 3; m_row = (int'(key_code) - 1) / 3; end
        end else if (m_active) begin
            m_k++;
            if (m_k == m_len) begin
                m_active = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] exp_scan;
        exp_scan = (m_active && m_ok && pressed(m_k) && column_sel[m_col]) ? 4'(1 << m_row) : 4'd0;
        check("scan_data", 32'(scan_data), 32'(exp_scan));
        check("key_ready", 32'(key_ready), 32'(!m_active));
        check("busy", 32'(busy), 32'(m_active));
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
    endtask

    initial begin
        m_active = 1'b0; m_ok = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_k = 0; m_len = 0; m_col = 0; m_row = 0;
        rst = 1'b1;
        key_valid = 1'b1;
        key_code = 4'd5;
        column_sel = 3'b111;
        repeat (2) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
        end
        rst = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            rst = $urandom_range(0, 149) == 0;
            if ($urandom_range(0, 3) == 0) key_valid = ~key_valid;
            if ($urandom_range(0, 2) == 0) key_code = 4'($urandom_range(0, 15));
            column_sel = $urandom_range(0, 1) ? 3'($urandom_range(0, 7)) : 3'(1 << (n % 3));
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Synthesizable device-side model of the 3-column x 4-row matrix keypad that the keypad scanner reads.
- Accepts key-press commands over a valid/ready handshake, then "presses" that key with contact bounce, a hold time and a release gap.
- Drives the row lines (scan_data) in response to the scanner's column select.
- Used for FPGA self-test and for closed-loop keypad verification.

Parameters:
- BOUNCE_CYCLES, 4, cycles of contact chatter at press and at release (>=1)
- HOLD_CYCLES, 64, cycles key is solidly pressed (>=1)
- GAP_CYCLES, 32, cycles with no key pressed after release (>=1)
- CNT_W, 8, phase counter width; must hold max(BOUNCE_CYCLES, HOLD_CYCLES, GAP_CYCLES)-1

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- key_code  input  4  key to press: 0-9, 10 (*), 11 (#); 12-15 invalid
- key_valid  input  1  command valid
- key_ready  output  1  emulator can accept a command
- column_sel  input  3  one-hot column drive from the scanner
- scan_data  output  4  one-hot row lines back to the scanner; 0 = nothing pressed
- busy  output  1  command in progress
- done  output  1  one-cycle pulse when a command completes
- err  output  1  one-cycle pulse when an invalid code is accepted

Behaviour:
- Reset values: state IDLE, counter 0, press_active 0, key_ready 1, busy 0, done 0, err 0, scan_data 0. A reset mid-operation aborts the press; scan_data is 0 from the cycle after the reset edge.
- Key map (code -> column, row):
  - Column 0: 1->(0,0), 4->(0,1), 7->(0,2), 10->(0,3)
  - Column 1: 2->(1,0), 5->(1,1), 8->(1,2), 0->(1,3)
  - Column 2: 3->(2,0), 6->(2,1), 9->(2,2), 11->(2,3)
- scan_data is combinational: scan_data = (press_active && column_sel[col]) ? (1<<row) : 0.
  - No register in this path. The scanner decodes column and row in the same cycle.
  - Multi-hot column_sel is a bit test: the row is driven if the key's column bit is set.
- States and transitions:
  - IDLE: key_ready=1, busy=0. On key_valid && key_ready, latch code, clear counter.
    - Valid code -> BOUNCE_IN.
    - Invalid code -> GAP, with err=1 in the cycle after acceptance. No press occurs.
  - BOUNCE_IN: press_active = ~cnt[0], so the first bounce cycle is pressed. At cnt==BOUNCE_CYCLES-1 -> HOLD.
  - HOLD: press_active=1. At cnt==HOLD_CYCLES-1 -> BOUNCE_OUT.
  - BOUNCE_OUT: press_active = ~cnt[0]. At cnt==BOUNCE_CYCLES-1 -> GAP.
  - GAP: press_active=0. At cnt==GAP_CYCLES-1 -> IDLE, with done=1 in the first IDLE cycle.
- Counter:
  - Increments every non-IDLE cycle.
  - Clears to 0 on every state change.
  - Never wraps within a phase.
- key_ready and busy:
  - key_ready=0 in all states except IDLE. key_valid while busy is ignored; the command stays pending.
  - busy = !key_ready.
- Back-to-back commands: a command accepted in the same IDLE cycle that done pulses is legal. The next press starts the cycle after.
- Latency: acceptance edge -> first pressed cycle = 1 cycle. Command occupancy:
  - Valid code: 2*BOUNCE_CYCLES+HOLD_CYCLES+GAP_CYCLES cycles.
  - Invalid code: GAP_CYCLES cycles.
- key_code is sampled only at acceptance. Later changes have no effect.

Decomposition:
- keypad_pkg holds:
  - State encodings.
  - Key code constants KEY_STAR=10, KEY_HASH=11, KEY_NONE=4'hF.
  - Column and row count constants (3, 4).
- One sub-module, keypad_key_map: combinational, code[3:0] -> col[1:0], row[1:0], code_ok. This is the same table the scanner decodes and is reusable by other benches.

Test Plan:
- Reset: hold rst for 2 cycles with key_valid=1 -> scan_data=0, key_ready=1, busy=0, done=0, err=0; no command accepted.
- key 5, B=2, H=4, G=3, column_sel=010 held:
  - scan_data = 0010, 0000, 0010 x4, 0010, 0000, then 0000 x3.
  - done pulses in the next cycle.
  - Same run with column_sel=001 -> scan_data 0 throughout.
- key 11, column_sel rotating 001/010/100 each cycle -> scan_data=1000 only in cycles where column_sel=100 and press_active=1; 0 otherwise.
- key 14 -> err pulse, scan_data 0 for all column_sel values, busy for exactly G cycles, then done.
- key_valid held high with 7 then 8 -> second accepted only in the done cycle; 8 pressed starting the next cycle.
- Reset asserted mid-HOLD on key 0 -> scan_data 0 and key_ready=1 from the next cycle. In a closed loop with the scanner and no reset, the scanner outputs keyData=0 in every column-1 phase during HOLD.
